rcv_frame_controller: RTL and testbench

//  Receive-side controller for the asynchronous serial link; sits directly upstream of the LSB-first flex STP shift register.
//  - Detects the start bit on serial_in and times mid-bit samples.
//  - Pulses sr_shift_enable once per bit so the shift register captures data plus stop bit, LSB-first.
//  - Checks the stop bit and moves the packet into a one-deep rx buffer with ready/overrun/framing flags.

---
 rtl/rcv_frame_controller.sv | 153 +++++++++++++++
 tb/tb_rcv_frame_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rcv_frame_controller.sv
// Receive-side frame controller: start detect, mid-bit shift pulses, stop check and one-deep rx buffer.
// Define RCV_PARITY_EN to add an even-parity bit before the stop bit and a parity_error output.
module rcv_frame_controller #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8,
`ifdef RCV_PARITY_EN
   localparam int PKT_W       = DATA_BITS + 2
`else
   localparam int PKT_W       = DATA_BITS + 1
`endif
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 serial_in,
   input  logic [PKT_W-1:0]     sr_packet,
   output logic                 sr_shift_enable,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   output logic                 overrun_error,
`ifdef RCV_PARITY_EN
   output logic                 parity_error,
`endif
   output logic                 framing_error
);

   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W = $clog2(PKT_W);
   localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_W - 1);

   typedef enum logic [2:0] {IDLE, START_CHK, RECV, STOP_CHK, LOAD} state_t;

   state_t               state, state_nxt;
   logic [TMR_W-1:0]     timer, timer_nxt;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic                 serial_in_q;
   logic [DATA_BITS-1:0] rx_data_nxt;
   logic                 data_ready_nxt, overrun_nxt, framing_nxt;
   logic                 start_edge;
`ifdef RCV_PARITY_EN
   logic                 parity_nxt;
`endif

   assign start_edge = serial_in_q & ~serial_in;

   // NOTE: every register updates with <= so all of them see the same pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= IDLE;
         timer         <= '0;
         bit_cnt       <= '0;
         serial_in_q   <= 1'b1;
         rx_data       <= '1;
         data_ready    <= 1'b0;
         overrun_error <= 1'b0;
         framing_error <= 1'b0;
`ifdef RCV_PARITY_EN
         parity_error  <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         bit_cnt       <= bit_cnt_nxt;
         serial_in_q   <= serial_in;
         rx_data       <= rx_data_nxt;
         data_ready    <= data_ready_nxt;
         overrun_error <= overrun_nxt;
         framing_error <= framing_nxt;
`ifdef RCV_PARITY_EN
         parity_error  <= parity_nxt;
`endif
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      timer_nxt       = timer;
      bit_cnt_nxt     = bit_cnt;
      rx_data_nxt     = rx_data;
      data_ready_nxt  = data_ready;
      overrun_nxt     = overrun_error;
      framing_nxt     = framing_error;
`ifdef RCV_PARITY_EN
      parity_nxt      = parity_error;
`endif
      sr_shift_enable = 1'b0;

      if (data_read && data_ready) begin
         data_ready_nxt = 1'b0;
         overrun_nxt    = 1'b0;
      end

      case (state)
         IDLE: begin
            if (start_edge) begin
               state_nxt   = START_CHK;
               timer_nxt   = '0;
               framing_nxt = 1'b0;
`ifdef RCV_PARITY_EN
               parity_nxt  = 1'b0;
`endif
            end
         end
         START_CHK: begin
            if (timer == TMR_HALF) begin
               timer_nxt = '0;
               state_nxt = serial_in ? IDLE : RECV;
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         RECV: begin
            if (timer == TMR_LAST) begin
               sr_shift_enable = 1'b1;
               timer_nxt       = '0;
               if (bit_cnt == CNT_LAST) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = STOP_CHK;
               end else begin
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         STOP_CHK: begin
            if (!sr_packet[PKT_W-1]) begin
               framing_nxt = 1'b1;
               state_nxt   = IDLE;
`ifdef RCV_PARITY_EN
            end else if (^sr_packet[DATA_BITS:0]) begin
               parity_nxt  = 1'b1;
               state_nxt   = IDLE;
`endif
            end else begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            // A read landing on the load cycle consumes the old byte, so it is not an overrun.
            rx_data_nxt    = sr_packet[DATA_BITS-1:0];
            data_ready_nxt = 1'b1;
            overrun_nxt    = data_read ? 1'b0 : (overrun_error | data_ready);
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rcv_frame_controller.sv
// Bench for rcv_frame_controller: directed frames plus random frames against a frame-level model,
// with a behavioural LSB-first shift register standing in for the flex STP shift register.
module tb_rcv_frame_controller;

   localparam int CPB         = 10;
   localparam int DB          = 8;
   localparam int PKT_W       = DB + 1;
   localparam int FIRST_SHIFT = CPB / 2 + CPB;
   localparam int LAST_SHIFT  = FIRST_SHIFT + (PKT_W - 1) * CPB;
   localparam int FRAME_CYC   = CPB * (DB + 2);

   logic           clk = 1'b0;
   logic           n_rst = 1'b1;
   logic           serial_in = 1'b1;
   logic           data_read = 1'b0;
   logic [PKT_W-1:0] sr_packet;
   logic           sr_shift_enable;
   logic [DB-1:0]  rx_data;
   logic           data_ready, overrun_error, framing_error;

   int n_checks = 0;
   int n_pass   = 0;

   // Frame-level model of the rx buffer and flags.
   logic [DB-1:0] m_data;
   logic          m_ready, m_overrun, m_framing;

   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)               sr_packet <= '1;
      else if (sr_shift_enable) sr_packet <= {serial_in, sr_packet[PKT_W-1:1]};
   end

   rcv_frame_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .serial_in      (serial_in),
      .sr_packet      (sr_packet),
      .sr_shift_enable(sr_shift_enable),
      .data_read      (data_read),
      .rx_data        (rx_data),
      .data_ready     (data_ready),
      .overrun_error  (overrun_error),
      .framing_error  (framing_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_rx_data"},       32'(rx_data),       32'(m_data));
      check({tag, "_data_ready"},    32'(data_ready),    32'(m_ready));
      check({tag, "_overrun_error"}, 32'(overrun_error), 32'(m_overrun));
      check({tag, "_framing_error"}, 32'(framing_error), 32'(m_framing));
   endtask

   task automatic model_reset();
      m_data    = '1;
      m_ready   = 1'b0;
      m_overrun = 1'b0;
      m_framing = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         serial_in = 1'b1;
      end
   endtask

   task automatic do_read();
      @(negedge clk);
      data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
      if (m_ready) begin
         m_ready   = 1'b0;
         m_overrun = 1'b0;
      end
      check_outputs("read");
   endtask

   // One frame; iteration i drives the line for the bit sampled at posedge (start edge + i)
   // and checks that a shift pulse is pending exactly at the mid-bit posedges.
   task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit,
                             input logic read_at_load, input int abort_at);
      logic [DB+1:0] bits;
      logic          exp_pulse;
      bits = {stop_bit, data, 1'b0};
      for (int i = 0; i <= FRAME_CYC; i++) begin
         @(negedge clk);
         if (i == abort_at) begin
            n_rst     = 1'b0;
            serial_in = 1'b1;
            #1;
            model_reset();
            check("reset_shift_enable", 32'(sr_shift_enable), 32'd0);
            check_outputs("reset");
            @(negedge clk);
            n_rst = 1'b1;
            return;
         end
         serial_in = (i < FRAME_CYC) ? bits[i / CPB] : 1'b1;
         exp_pulse = (i >= FIRST_SHIFT) && (i <= LAST_SHIFT) && ((i - FIRST_SHIFT) % CPB == 0);
         check("shift_pulse", 32'(sr_shift_enable), 32'(exp_pulse));
         if (i == 1) begin
            m_framing = 1'b0;
            check_outputs("start");
         end
         if (i == LAST_SHIFT + 2) data_read = read_at_load;
         if (i == LAST_SHIFT + 3) begin
            data_read = 1'b0;
            check("packet", 32'(sr_packet), 32'({stop_bit, data}));
            if (!stop_bit) begin
               m_framing = 1'b1;
               if (read_at_load) begin
                  m_ready   = 1'b0;
                  m_overrun = 1'b0;
               end
            end else begin
               if (read_at_load) m_overrun = 1'b0;
               else if (m_ready) m_overrun = 1'b1;
               m_ready = 1'b1;
               m_data  = data;
            end
            check_outputs("frame_end");
         end
      end
   endtask

   task automatic send_glitch(input int low_cycles);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         serial_in = (i < low_cycles) ? 1'b0 : 1'b1;
         check("glitch_shift_pulse", 32'(sr_shift_enable), 32'd0);
         if (i == 1) m_framing = 1'b0;
      end
      check_outputs("glitch");
   endtask

   initial begin
      model_reset();
      #2 n_rst = 1'b0;
      #1;
      check("por_shift_enable", 32'(sr_shift_enable), 32'd0);
      check_outputs("por");
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      idle(3);

      send_frame(8'hA5, 1'b1, 1'b0, -1);
      idle(3);
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      idle(3);
      do_read();
      idle(3);
      send_frame(8'h5A, 1'b0, 1'b0, -1);
      idle(5);
      send_frame(8'h12, 1'b1, 1'b0, -1);
      idle(3);
      send_glitch(3);
      idle(3);
      send_frame(8'hC3, 1'b1, 1'b0, LAST_SHIFT - 5 * CPB + 5);
      idle(3);
      send_frame(8'hFF, 1'b1, 1'b0, -1);
      idle(3);
      send_frame(8'h81, 1'b1, 1'b1, -1);
      idle(3);

      for (int n = 0; n < 16; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) send_glitch(int'($urandom_range(1, CPB / 2 - 1)));
         else send_frame(8'($urandom), r != 1, 1'($urandom_range(0, 1)), -1);
         if ($urandom_range(0, 2) == 0) do_read();
         idle(int'($urandom_range(2, 6)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
